oc_sweep_controller: RTL and testbench
======================================

Name: oc_sweep_controller

Overview:
- Sequencer that exhaustively exercises a 3-input/2-output combinational gate pair (the OC_Q3_y0 / OC_Q4_y1 style cells) in hardware.
- Drives a,b,c through all 8 codes, holding each for a programmable settle time, then captures y0/y1.
- Compares the captured outputs against expected truth tables and reports the first failing code.
- Sits between a simple start/done host and the gate-under-test; it replaces timed-delay stimulus with a synthesizable sweep.

Parameters:
- SETTLE_CYCLES, 79, clock cycles each input code is held before sampling; legal range 1..1023.
- EXP_Y0, 8'h00, expected y0 truth table; bit i corresponds to {a,b,c}==i.
- EXP_Y1, 8'h00, expected y1 truth table; same indexing as EXP_Y0.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse or level; sampled only in IDLE.
- abort  in  1  ends a run early; sampled only while busy.
- a  out  1  stimulus MSB; registered.
- b  out  1  stimulus middle bit; registered.
- c  out  1  stimulus LSB; registered.
- y0  in  1  gate-under-test output 0.
- y1  in  1  gate-under-test output 1.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a full sweep completes.
- result_y0  out  8  captured y0 per code.
- result_y1  out  8  captured y1 per code.
- mismatch  out  1  at least one captured bit differed from EXP_*.
- fail_idx  out  3  first code that mismatched; 0 if none.

Behaviour:
- Reset: on the edge with rst=1, state=IDLE and all outputs are 0: a, b, c, busy, done, result_y0, result_y1, mismatch, fail_idx. The index idx and settle count cnt are also 0. rst has priority over start and abort and takes effect mid-run.
- States are IDLE, SETTLE and DONE.
- IDLE -> SETTLE when start=1.
  - Same edge: idx<=0, cnt<=0, {a,b,c}<=3'b000, busy<=1, mismatch<=0, fail_idx<=0, result_y0/result_y1<=0.
- In SETTLE:
  - {a,b,c} always equals idx.
  - cnt increments each edge.
  - At the edge where cnt==SETTLE_CYCLES-1:
    - result_y0[idx]<=y0 and result_y1[idx]<=y1.
    - cnt<=0.
    - If y0!=EXP_Y0[idx] or y1!=EXP_Y1[idx] and mismatch==0, then mismatch<=1 and fail_idx<=idx. mismatch is sticky; fail_idx keeps the first failure.
    - If idx<7: idx<=idx+1 and {a,b,c} follow idx.
    - If idx==7: state<=DONE, done<=1, busy<=0, {a,b,c}<=000.
- DONE lasts exactly one cycle, then returns to IDLE with done<=0. start seen during DONE is ignored.
- Latency: if start is accepted at edge E0, code i is held from E0+i*S to E0+(i+1)*S, where S=SETTLE_CYCLES. Capture of code i happens at edge E0+(i+1)*S. done is high in the cycle following edge E0+8*S.
- With SETTLE_CYCLES=1, each code is driven for exactly one cycle and sampled at the next edge.
- start while busy is ignored; there is no queueing.
- abort=1 in SETTLE:
  - Next edge goes to IDLE with busy<=0 and {a,b,c}<=000.
  - No done pulse.
  - result_y0/result_y1, mismatch and fail_idx keep their partial values.
  - Capture and abort on the same edge: the capture is performed, then the run aborts.
- result_y0, result_y1, mismatch and fail_idx hold their values in IDLE until the next accepted start or rst.
- idx never wraps; the sweep ends after code 7.

Decomposition:
- Shared include oc_sweep_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_SETTLE=2'd1, ST_DONE=2'd2;
  - the counter width CNT_W=10;
  - the expected-table constants for the team's gate pairs, e.g. majority = 8'hE8.
- One sub-module, oc_settle_timer: cnt register with clear/enable inputs and a registered-free "expire" output (cnt==SETTLE_CYCLES-1). The FSM, capture and compare logic stay in the top.

Test Plan:
- Sweep with a correct gate: SETTLE_CYCLES=4, gate y0=maj(a,b,c), y1=a^b^c, EXP_Y0=8'hE8, EXP_Y1=8'h96; start pulse at edge E0 -> done pulse at E0+32, result_y0=8'hE8, result_y1=8'h96, mismatch=0, fail_idx=0. {a,b,c} steps 000..111, changing every 4 cycles.
- Single fault: same setup, gate model forces y0=0 for code 5 -> result_y0=8'hC8, mismatch=1, fail_idx=5. Add a second fault at code 6 -> fail_idx stays 5.
- Minimum settle: SETTLE_CYCLES=1 -> each code is held for 1 cycle; done at E0+8; capture alignment matches the code driven in the preceding cycle.
- Abort: SETTLE_CYCLES=4, abort=1 during cycle E0+10 (code 2) -> IDLE at the next edge, no done, busy=0, {a,b,c}=000. result bits 0-1 hold captured values and bits 2-7 stay 0.
- Reset mid-run: rst=1 at E0+13 -> all outputs 0 at that edge. A start held high across the reset begins a fresh sweep on the first edge after rst drops.
- Start while busy and during DONE: start pulses at E0+5 and in the done cycle -> both ignored; exactly one done pulse; a start one cycle after done is accepted.

Source files
------------

// File: rtl/oc_sweep_controller_pkg.sv
// Shared types and constants for the gate-pair sweep controller.
package oc_sweep_controller_pkg;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned NUM_CODES = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

    // Expected truth tables for the team's gate pairs; bit i is the output for {a,b,c}==i.
    localparam logic [NUM_CODES-1:0] EXP_MAJ3 = 8'hE8;
    localparam logic [NUM_CODES-1:0] EXP_XOR3 = 8'h96;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Captured sweep outcome as presented to the host.
    typedef struct packed {
        logic [NUM_CODES-1:0] r_y0;
        logic [NUM_CODES-1:0] r_y1;
        logic                 mismatch;
        logic [IDX_W-1:0]     fail_idx;
    } sweep_result_t;

endpackage

// File: rtl/oc_sweep_controller_settle_timer.sv
// Settle counter: counts cycles a stimulus code has been held and flags the sample cycle.
module oc_settle_timer
    import oc_sweep_controller_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 79
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    logic [CNT_W-1:0] cnt;

    // Clear has priority so the count restarts from zero on the sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire_c = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/oc_sweep_controller.sv
// Exhaustive 3-input sweep of a gate pair with capture and compare against expected tables.
module oc_sweep_controller
    import oc_sweep_controller_pkg::*;
#(
    parameter int unsigned          SETTLE_CYCLES = 79,
    parameter logic [NUM_CODES-1:0] EXP_Y0        = 8'h00,
    parameter logic [NUM_CODES-1:0] EXP_Y1        = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    input  logic                 y0,
    input  logic                 y1,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_CODES-1:0] result_y0,
    output logic [NUM_CODES-1:0] result_y1,
    output logic                 mismatch,
    output logic [IDX_W-1:0]     fail_idx
);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [IDX_W-1:0] abc, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    sweep_result_t    res, res_d;

    logic expire_c;
    logic timer_clear_c;
    logic timer_enable_c;
    logic code_bad_c;

    // Timer runs only while settling and restarts on every sample or abort.
    assign timer_enable_c = (state == ST_SETTLE);
    assign timer_clear_c  = (state != ST_SETTLE) || expire_c || abort;

    oc_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear_c),
        .enable   (timer_enable_c),
        .expire_c (expire_c)
    );

    assign code_bad_c = (y0 != EXP_Y0[idx]) || (y1 != EXP_Y1[idx]);

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            abc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res    <= '0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            abc    <= abc_d;
            busy_q <= busy_d;
            done_q <= done_d;
            res    <= res_d;
        end
    end

    // Next-state: start, per-code capture/compare, completion and abort.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        abc_d   = abc;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = '0;
                    abc_d   = '0;
                    busy_d  = 1'b1;
                    res_d   = '0;
                end
            end

            ST_SETTLE: begin
                if (expire_c) begin
                    res_d.r_y0[idx] = y0;
                    res_d.r_y1[idx] = y1;
                    if (code_bad_c && !res.mismatch) begin
                        res_d.mismatch = 1'b1;
                        res_d.fail_idx = idx;
                    end
                    if (idx == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        abc_d   = '0;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                        abc_d = idx + IDX_W'(1);
                    end
                end
                // Abort wins over completion but keeps any capture made on this edge.
                if (abort) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    abc_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                abc_d   = '0;
            end
        endcase
    end

    assign a         = abc[2];
    assign b         = abc[1];
    assign c         = abc[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign result_y0 = res.r_y0;
    assign result_y1 = res.r_y1;
    assign mismatch  = res.mismatch;
    assign fail_idx  = res.fail_idx;

endmodule

// File: tb/tb_oc_sweep_controller.sv
// Scoreboard bench for oc_sweep_controller: a settle-4 and a settle-1 instance with faultable gate models.
module tb_oc_sweep_controller;
    import oc_sweep_controller_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, abort4, start1, abort1;
    logic       a4, b4, c4, a1, b1, c1;
    logic       y0_4, y1_4, y0_1, y1_1;
    logic       busy4, done4, busy1, done1;
    logic [7:0] r0_4, r1_4, r0_1, r1_1;
    logic       mism4, mism1;
    logic [2:0] fidx4, fidx1;
    logic [7:0] flip4, flip1;
    logic [2:0] abc4, abc1;

    int n_vec = 0;
    int n_err = 0;

    sweep_result_t q4[$];
    sweep_result_t q1[$];

    oc_sweep_controller #(.SETTLE_CYCLES(4), .EXP_Y0(EXP_MAJ3), .EXP_Y1(EXP_XOR3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .a(a4), .b(b4), .c(c4), .y0(y0_4), .y1(y1_4),
        .busy(busy4), .done(done4), .result_y0(r0_4), .result_y1(r1_4),
        .mismatch(mism4), .fail_idx(fidx4)
    );

    oc_sweep_controller #(.SETTLE_CYCLES(1), .EXP_Y0(EXP_MAJ3), .EXP_Y1(EXP_XOR3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .y0(y0_1), .y1(y1_1),
        .busy(busy1), .done(done1), .result_y0(r0_1), .result_y1(r1_1),
        .mismatch(mism1), .fail_idx(fidx1)
    );

    function automatic logic maj3(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    // Gate-under-test models: majority (optionally flipped per code) and 3-input xor.
    assign abc4 = {a4, b4, c4};
    assign abc1 = {a1, b1, c1};
    assign y0_4 = maj3(abc4) ^ flip4[abc4];
    assign y1_4 = ^abc4;
    assign y0_1 = maj3(abc1) ^ flip1[abc1];
    assign y1_1 = ^abc1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic sweep_result_t predict(input logic [7:0] flip);
        sweep_result_t r;
        logic [2:0]    v;
        logic          found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v         = 3'(i);
            r.r_y0[i] = maj3(v) ^ flip[i];
            r.r_y1[i] = ^v;
        end
        for (int i = 0; i < 8; i++) begin
            if (!found && ((r.r_y0[i] != EXP_MAJ3[i]) || (r.r_y1[i] != EXP_XOR3[i]))) begin
                found      = 1'b1;
                r.fail_idx = 3'(i);
            end
        end
        r.mismatch = found;
        return r;
    endfunction

    // Pop the expected outcome whenever a DUT reports done.
    always @(negedge clk) begin
        sweep_result_t e;
        if (done4) begin
            if (q4.size() == 0) check_eq("done4_unexpected", 32'(done4), 32'd0);
            else begin
                e = q4.pop_front();
                check_eq("res_y0_s4", 32'(r0_4), 32'(e.r_y0));
                check_eq("res_y1_s4", 32'(r1_4), 32'(e.r_y1));
                check_eq("mismatch_s4", 32'(mism4), 32'(e.mismatch));
                check_eq("fail_idx_s4", 32'(fidx4), 32'(e.fail_idx));
            end
        end
        if (done1) begin
            if (q1.size() == 0) check_eq("done1_unexpected", 32'(done1), 32'd0);
            else begin
                e = q1.pop_front();
                check_eq("res_y0_s1", 32'(r0_1), 32'(e.r_y0));
                check_eq("res_y1_s1", 32'(r1_1), 32'(e.r_y1));
                check_eq("mismatch_s1", 32'(mism1), 32'(e.mismatch));
                check_eq("fail_idx_s1", 32'(fidx1), 32'(e.fail_idx));
            end
        end
    end

    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v;
        else     start4 = v;
    endtask

    function automatic logic [2:0] abc_of(input bit sel);
        return sel ? abc1 : abc4;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy4;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done1 : done4;
    endfunction

    // One-cycle start pulse; returns 1ns after the accepting edge.
    task automatic start_sweep(input bit sel, input bit push);
        @(posedge clk);
        #1 set_start(sel, 1'b1);
        @(posedge clk);
        if (push) begin
            if (sel) q1.push_back(predict(flip1));
            else     q4.push_back(predict(flip4));
        end
        #1 set_start(sel, 1'b0);
    endtask

    // Per-cycle stimulus/busy/done timing; optionally pokes start while busy and in the done cycle.
    task automatic check_sweep(input bit sel, input int s, input bit inject);
        for (int k = 0; k <= 8 * s + 1; k++) begin
            @(negedge clk);
            check_eq("abc", 32'(abc_of(sel)), (k < 8 * s) ? 32'(k / s) : 32'd0);
            check_eq("busy", 32'(busy_of(sel)), 32'(k < 8 * s));
            check_eq("done", 32'(done_of(sel)), 32'(k == 8 * s));
            if (inject) set_start(sel, (k == 5) || (k == 8 * s));
        end
    endtask

    task automatic check_all_zero(input bit sel);
        check_eq("rst_abc", 32'(abc_of(sel)), 32'd0);
        check_eq("rst_busy", 32'(busy_of(sel)), 32'd0);
        check_eq("rst_done", 32'(done_of(sel)), 32'd0);
        check_eq("rst_r0", sel ? 32'(r0_1) : 32'(r0_4), 32'd0);
        check_eq("rst_r1", sel ? 32'(r1_1) : 32'(r1_4), 32'd0);
        check_eq("rst_mism", sel ? 32'(mism1) : 32'(mism4), 32'd0);
        check_eq("rst_fidx", sel ? 32'(fidx1) : 32'(fidx4), 32'd0);
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start4 = 1'b0; abort4 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
        flip4 = 8'h00; flip1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero(1'b0);
        check_all_zero(1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Correct gate, with start pokes while busy and in the done cycle.
        flip4 = 8'h00;
        start_sweep(1'b0, 1'b1);
        check_sweep(1'b0, 4, 1'b1);

        // Single fault at code 5, then a second fault at code 6.
        flip4 = 8'h20;
        start_sweep(1'b0, 1'b1);
        check_sweep(1'b0, 4, 1'b0);
        flip4 = 8'h60;
        start_sweep(1'b0, 1'b1);
        check_sweep(1'b0, 4, 1'b0);

        // Minimum settle with a fault at code 3 to expose capture alignment.
        flip1 = 8'h08;
        start_sweep(1'b1, 1'b1);
        check_sweep(1'b1, 1, 1'b1);

        // Abort during code 2, with code 1 faulted.
        flip4 = 8'h02;
        start_sweep(1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 abort4 = 1'b1;
        @(posedge clk);
        #1 abort4 = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy4), 32'd0);
        check_eq("abort_abc", 32'(abc4), 32'd0);
        check_eq("abort_done", 32'(done4), 32'd0);
        check_eq("abort_r0", 32'(r0_4), 32'h02);
        check_eq("abort_r1", 32'(r1_4), 32'h02);
        check_eq("abort_mism", 32'(mism4), 32'd1);
        check_eq("abort_fidx", 32'(fidx4), 32'd1);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done4 || busy4) saw_done = 1'b1;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'd0);
        check_eq("abort_hold_r1", 32'(r1_4), 32'h02);

        // Reset mid-run with start held across it.
        flip4 = 8'h00;
        start_sweep(1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero(1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        q4.push_back(predict(flip4));
        #1 start4 = 1'b0;
        check_sweep(1'b0, 4, 1'b0);

        repeat (3) @(negedge clk);
        check_eq("q4_drained", 32'(q4.size()), 32'd0);
        check_eq("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
